// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds the FSM state enum, register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] OFF_TXDATA = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd4;
  localparam logic [31:0] OFF_CTRL   = 32'd8;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// MEM-stage bus bundle seen by the UART: EX/MEM controls in,
// load data and hit out.
interface uart_tx_mmio_if;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output mem_write, mem_read, address, write_data,
    input  read_data, hit
  );

  modport slave (
    input  mem_write, mem_read, address, write_data,
    output read_data, hit
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO 8N1 UART transmitter beside DataMemory: TXDATA/STATUS registers.
// Define UART_TX_IRQ_EN to add the CTRL register and the irq output.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
`ifdef UART_TX_IRQ_EN
  output logic           irq,
`endif
  output logic           tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0] A_TX = BASE_ADDR + OFF_TXDATA;
  localparam logic [31:0] A_ST = BASE_ADDR + OFF_STATUS;

  tx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          ovf;
  logic          done;
  logic          pop;

  logic          sel_tx, sel_st, sel_ct;
  logic          push_req, push, ovf_evt, rd_st;
  logic [7:0]    head;
  logic          full, empty;
  logic [NW-1:0] count;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          unused_wdata;

  assign unused_wdata = ^bus.write_data[31:8];

  assign sel_tx = (bus.address == A_TX);
  assign sel_st = (bus.address == A_ST);
`ifdef UART_TX_IRQ_EN
  assign sel_ct = (bus.address == BASE_ADDR + OFF_CTRL);
`else
  assign sel_ct = 1'b0;
`endif

  assign bus.hit = (bus.mem_read | bus.mem_write)
                 & (sel_tx | sel_st | sel_ct);

  assign push_req = bus.mem_write & sel_tx;
  assign push     = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;
  assign rd_st    = bus.mem_read & sel_st;
  assign done     = (cnt == CW'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.write_data[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
      ovf   <= ovf_evt | (ovf & ~rd_st);
    end
  end

  // STOP pops directly into START so queued frames run back-to-back
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
        end
      end
      START: if (done) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = DATA;
      end
      DATA: if (done) begin
        cnt_n   = '0;
        shift_n = shift >> 1;
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (done) begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      IDLE,
      STOP:    tx_n = 1'b1;
    endcase
    status               = '0;
    status[ST_BUSY]      = (state != IDLE);
    status[ST_FULL]      = full;
    status[ST_EMPTY]     = empty;
    status[ST_OVF]       = ovf;
    status[ST_CNT +: 4]  = 4'(count);
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en, irq_en_n;

  assign irq_en_n = (bus.mem_write & sel_ct) ? bus.write_data[0] : irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_n;
      irq    <= irq_en_n & empty & (state_n == IDLE);
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.mem_read & sel_st)      rdata = status;
    else if (bus.mem_read & sel_ct) rdata = {31'b0, irq_en};
  end
`else
  always_comb begin
    rdata = '0;
    if (rd_st) rdata = status;
  end
`endif

  assign bus.read_data = rdata;
endmodule
